// File: rtl/axi_pkg.sv
// Shared AXI constants and the responder FSM/arbiter encodings.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      WBEAT,
      WRESP,
      RBEAT
   } state_t;

   typedef enum logic {
      GRANT_READ,
      GRANT_WRITE
   } grant_t;

endpackage

// File: rtl/axi_mem_ram.sv
module axi_mem_ram #(
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wstrb,
  input  logic [63:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [63:0]           rdata
);

  logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: one burst at a time, round-robin read/write arbitration.
module axi_mem_responder
   import axi_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 16,
   parameter logic [63:0] BASE       = 64'h8000_0000,
   parameter string       INIT_FILE  = ""
) (
   input  logic        CLK,
   input  logic        RST,

   input  logic        MEM_AWID,
   input  logic [63:0] MEM_AWADDR,
   input  logic [7:0]  MEM_AWLEN,
   input  logic [1:0]  MEM_AWBURST,
   input  logic [2:0]  MEM_AWSIZE,
   input  logic        MEM_AWLOCK,
   input  logic [3:0]  MEM_AWCACHE,
   input  logic [2:0]  MEM_AWPROT,
   input  logic [3:0]  MEM_AWQOS,
   input  logic        MEM_AWUSER,
   input  logic        MEM_AWVALID,
   output logic        MEM_AWREADY,

   input  logic [63:0] MEM_WDATA,
   input  logic [7:0]  MEM_WSTRB,
   input  logic        MEM_WLAST,
   input  logic        MEM_WUSER,
   input  logic        MEM_WVALID,
   output logic        MEM_WREADY,

   output logic        MEM_BID,
   output logic [1:0]  MEM_BRESP,
   output logic        MEM_BUSER,
   output logic        MEM_BVALID,
   input  logic        MEM_BREADY,

   input  logic        MEM_ARID,
   input  logic [63:0] MEM_ARADDR,
   input  logic [7:0]  MEM_ARLEN,
   input  logic [1:0]  MEM_ARBURST,
   input  logic [2:0]  MEM_ARSIZE,
   input  logic        MEM_ARLOCK,
   input  logic [3:0]  MEM_ARCACHE,
   input  logic [2:0]  MEM_ARPROT,
   input  logic [3:0]  MEM_ARQOS,
   input  logic        MEM_ARUSER,
   input  logic        MEM_ARVALID,
   output logic        MEM_ARREADY,

   output logic        MEM_RID,
   output logic [63:0] MEM_RDATA,
   output logic [1:0]  MEM_RRESP,
   output logic        MEM_RLAST,
   output logic        MEM_RUSER,
   output logic        MEM_RVALID,
   input  logic        MEM_RREADY
);

   localparam logic [63:0] LIMIT = BASE + (64'd8 << DEPTH_LOG2);

   state_t                state;
   grant_t                last_grant;
   logic                  id;
   logic [63:0]           addr;
   logic [7:0]            len;
   logic [7:0]            cnt;
   logic [1:0]            burst;
   logic                  err;

   logic                  wready;
   logic                  bvalid;
   logic                  bid;
   logic [1:0]            bresp;
   logic                  rvalid;
   logic                  rid;

   logic                  aw_grant;
   logic                  ar_grant;
   logic                  in_range;
   logic                  last_beat;
   logic                  w_beat_err;
   logic [63:0]           next_addr;
   logic [63:0]           offset;
   logic [DEPTH_LOG2-1:0] idx;
   logic [63:0]           ram_rdata;
   logic                  ram_we;
   logic                  unused_inputs;

   // Ready is combinational from IDLE so the handshake completes in the grant cycle.
   always_comb begin
      aw_grant = 1'b0;
      ar_grant = 1'b0;
      if (state == IDLE) begin
         if (MEM_AWVALID && MEM_ARVALID) begin
            if (last_grant == GRANT_READ) aw_grant = 1'b1;
            else                          ar_grant = 1'b1;
         end else begin
            aw_grant = MEM_AWVALID;
            ar_grant = MEM_ARVALID;
         end
      end
   end

   always_comb begin
      next_addr = addr + 64'd8;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR,
         BURST_WRAP:  next_addr = addr + 64'd8;
         default:     next_addr = addr + 64'd8;
      endcase
   end

   assign offset     = addr - BASE;
   assign idx        = offset[DEPTH_LOG2+2:3];
   assign in_range   = (addr >= BASE) && (addr < LIMIT);
   assign last_beat  = (cnt == len);
   assign w_beat_err = (MEM_WLAST != last_beat) || !in_range;
   assign ram_we     = (state == WBEAT) && wready && MEM_WVALID && in_range;

   axi_mem_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .INIT_FILE  (INIT_FILE)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .waddr (idx),
      .wstrb (MEM_WSTRB),
      .wdata (MEM_WDATA),
      .raddr (idx),
      .rdata (ram_rdata)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         last_grant <= GRANT_READ;
         err        <= 1'b0;
         id         <= 1'b0;
         addr       <= '0;
         len        <= '0;
         cnt        <= '0;
         burst      <= BURST_INCR;
         wready     <= 1'b0;
         bvalid     <= 1'b0;
         bid        <= 1'b0;
         bresp      <= RESP_OKAY;
         rvalid     <= 1'b0;
         rid        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_grant) begin
                  id         <= MEM_AWID;
                  addr       <= MEM_AWADDR;
                  len        <= MEM_AWLEN;
                  burst      <= MEM_AWBURST;
                  cnt        <= '0;
                  err        <= 1'b0;
                  wready     <= 1'b1;
                  last_grant <= GRANT_WRITE;
                  state      <= WBEAT;
               end else if (ar_grant) begin
                  id         <= MEM_ARID;
                  rid        <= MEM_ARID;
                  addr       <= MEM_ARADDR;
                  len        <= MEM_ARLEN;
                  burst      <= MEM_ARBURST;
                  cnt        <= '0;
                  rvalid     <= 1'b1;
                  last_grant <= GRANT_READ;
                  state      <= RBEAT;
               end
            end

            WBEAT: begin
               if (MEM_WVALID) begin
                  // Burst length comes from AWLEN; WLAST only feeds the error flag.
                  if (last_beat) begin
                     wready <= 1'b0;
                     bvalid <= 1'b1;
                     bid    <= id;
                     bresp  <= (err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     state  <= WRESP;
                  end else begin
                     cnt    <= cnt + 8'd1;
                     addr   <= next_addr;
                  end
                  err <= err || w_beat_err;
               end
            end

            WRESP: begin
               if (MEM_BREADY) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end

            RBEAT: begin
               if (MEM_RREADY) begin
                  if (last_beat) begin
                     rvalid <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     cnt    <= cnt + 8'd1;
                     addr   <= next_addr;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign MEM_AWREADY = aw_grant;
   assign MEM_ARREADY = ar_grant;
   assign MEM_WREADY  = wready;
   assign MEM_BVALID  = bvalid;
   assign MEM_BID     = bid;
   assign MEM_BRESP   = bresp;
   assign MEM_BUSER   = 1'b0;

   // Beat fields depend only on addr/cnt, so they hold while the master stalls.
   assign MEM_RVALID  = rvalid;
   assign MEM_RID     = rid;
   assign MEM_RDATA   = (rvalid && in_range) ? ram_rdata : '0;
   assign MEM_RRESP   = (rvalid && !in_range) ? RESP_SLVERR : RESP_OKAY;
   assign MEM_RLAST   = rvalid && last_beat;
   assign MEM_RUSER   = 1'b0;

   assign unused_inputs = ^{MEM_AWSIZE, MEM_AWLOCK, MEM_AWCACHE, MEM_AWPROT, MEM_AWQOS,
                            MEM_AWUSER, MEM_WUSER, MEM_ARSIZE, MEM_ARLOCK, MEM_ARCACHE,
                            MEM_ARPROT, MEM_ARQOS, MEM_ARUSER,
                            offset[63:DEPTH_LOG2+3], offset[2:0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: bursts, arbitration, errors, backpressure, reset.
module tb_axi_mem_responder;
   import axi_pkg::*;

   localparam int unsigned DEPTH_LOG2 = 16;
   localparam logic [63:0] BASE       = 64'h8000_0000;
   localparam logic [63:0] LIMIT      = BASE + (64'd8 << DEPTH_LOG2);

   logic        clk = 1'b0;
   logic        rst;
   logic        awid, awvalid, awready;
   logic [63:0] awaddr;
   logic [7:0]  awlen;
   logic [1:0]  awburst;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic        bid, buser, bvalid, bready;
   logic [1:0]  bresp;
   logic        arid, arvalid, arready;
   logic [63:0] araddr;
   logic [7:0]  arlen;
   logic [1:0]  arburst;
   logic        rid, rlast, ruser, rvalid, rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        id;
   } rbeat_t;

   rbeat_t      sb[$];
   logic [63:0] wq[$];
   logic [63:0] model [longint unsigned];
   logic [63:0] cur_addr;
   logic [1:0]  cur_burst;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   axi_mem_responder #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .BASE       (BASE)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .MEM_AWID    (awid),
      .MEM_AWADDR  (awaddr),
      .MEM_AWLEN   (awlen),
      .MEM_AWBURST (awburst),
      .MEM_AWSIZE  (3'd3),
      .MEM_AWLOCK  (1'b0),
      .MEM_AWCACHE (4'd0),
      .MEM_AWPROT  (3'd0),
      .MEM_AWQOS   (4'd0),
      .MEM_AWUSER  (1'b0),
      .MEM_AWVALID (awvalid),
      .MEM_AWREADY (awready),
      .MEM_WDATA   (wdata),
      .MEM_WSTRB   (wstrb),
      .MEM_WLAST   (wlast),
      .MEM_WUSER   (1'b0),
      .MEM_WVALID  (wvalid),
      .MEM_WREADY  (wready),
      .MEM_BID     (bid),
      .MEM_BRESP   (bresp),
      .MEM_BUSER   (buser),
      .MEM_BVALID  (bvalid),
      .MEM_BREADY  (bready),
      .MEM_ARID    (arid),
      .MEM_ARADDR  (araddr),
      .MEM_ARLEN   (arlen),
      .MEM_ARBURST (arburst),
      .MEM_ARSIZE  (3'd3),
      .MEM_ARLOCK  (1'b0),
      .MEM_ARCACHE (4'd0),
      .MEM_ARPROT  (3'd0),
      .MEM_ARQOS   (4'd0),
      .MEM_ARUSER  (1'b0),
      .MEM_ARVALID (arvalid),
      .MEM_ARREADY (arready),
      .MEM_RID     (rid),
      .MEM_RDATA   (rdata),
      .MEM_RRESP   (rresp),
      .MEM_RLAST   (rlast),
      .MEM_RUSER   (ruser),
      .MEM_RVALID  (rvalid),
      .MEM_RREADY  (rready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit in_range(input logic [63:0] a);
      return (a >= BASE) && (a < LIMIT);
   endfunction

   function automatic logic [63:0] step(input logic [63:0] a, input logic [1:0] b);
      return (b == BURST_FIXED) ? a : a + 64'd8;
   endfunction

   task automatic push_read(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                            input logic i);
      logic [63:0] p = a;
      for (int k = 0; k <= int'(l); k++) begin
         rbeat_t e;
         e.id   = i;
         e.last = (k == int'(l));
         if (in_range(p)) begin
            e.data = model[longint'((p - BASE) >> 3)];
            e.resp = RESP_OKAY;
         end else begin
            e.data = '0;
            e.resp = RESP_SLVERR;
         end
         sb.push_back(e);
         p = step(p, b);
      end
   endtask

   task automatic aw_req(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic i);
      bit done = 0;
      awaddr = a; awlen = l; awburst = b; awid = i; awvalid = 1'b1;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         done = awready;
         tick();
      end
      awvalid = 1'b0;
      if (!done) check("aw_timeout", 64'd0, 64'd1);
      cur_addr = a; cur_burst = b;
   endtask

   task automatic ar_req(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic i);
      bit done = 0;
      araddr = a; arlen = l; arburst = b; arid = i; arvalid = 1'b1;
      push_read(a, l, b, i);
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         done = arready;
         tick();
      end
      arvalid = 1'b0;
      if (!done) check("ar_timeout", 64'd0, 64'd1);
   endtask

   // Drives n beats from wq, updates the memory model and reports the expected error flag.
   task automatic w_beats(input int n, input logic [7:0] strb, input int last_idx,
                          output bit err);
      err = 0;
      for (int k = 0; k < n; k++) begin
         bit got = 0;
         wvalid = 1'b1;
         wdata  = wq.pop_front();
         wstrb  = strb;
         wlast  = (k == last_idx);
         if ((k == last_idx) != (k == n - 1)) err = 1;
         for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (k == 0 && c == 0) check("wready_lat", {63'd0, wready}, 64'd1);
            got = wready;
            tick();
         end
         if (!got) check("w_timeout", 64'd0, 64'd1);
         if (in_range(cur_addr)) begin
            longint unsigned key = longint'((cur_addr - BASE) >> 3);
            logic [63:0] old = model.exists(key) ? model[key] : 64'd0;
            for (int j = 0; j < 8; j++)
               if (strb[j]) old[8*j +: 8] = wdata[8*j +: 8];
            model[key] = old;
         end else begin
            err = 1;
         end
         cur_addr = step(cur_addr, cur_burst);
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic b_wait(input logic i, input logic [1:0] resp);
      bit got = 0;
      bready = 1'b1;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         if (c == 0) check("b_lat", {63'd0, bvalid}, 64'd1);
         if (bvalid) begin
            check("bid", {63'd0, bid}, {63'd0, i});
            check("bresp", {62'd0, bresp}, {62'd0, resp});
            got = 1;
         end
         tick();
      end
      bready = 1'b0;
      if (!got) check("b_timeout", 64'd0, 64'd1);
   endtask

   // Pops n expected beats; stalled cycles compare the held beat against the queue head.
   task automatic r_collect(input int n, input bit rnd, input bit final_chk);
      int popped = 0;
      int cyc    = 0;
      while (popped < n && cyc < 4 * n + 100) begin
         rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (cyc == 0) check("r_lat", {63'd0, rvalid}, 64'd1);
         if (rvalid && sb.size() > 0) begin
            rbeat_t e = sb[0];
            if (rready) begin
               void'(sb.pop_front());
               check("r_data", rdata, e.data);
               check("r_resp", {62'd0, rresp}, {62'd0, e.resp});
               check("r_last", {63'd0, rlast}, {63'd0, e.last});
               check("r_id", {63'd0, rid}, {63'd0, e.id});
               popped++;
            end else begin
               check("r_hold", rdata, e.data);
            end
         end
         tick();
         cyc++;
      end
      rready = 1'b0;
      if (popped < n) check("r_timeout", 64'(popped), 64'(n));
      if (!rnd) check("r_b2b", 64'(cyc), 64'(n));
      if (final_chk) begin
         @(negedge clk);
         check("r_idle_valid", {63'd0, rvalid}, 64'd0);
         check("r_idle_data", rdata, 64'd0);
         tick();
      end
   endtask

   initial begin
      bit e;
      rst = 1'b1;
      {awid, awvalid, awaddr, awlen, awburst} = '0;
      {wdata, wstrb, wlast, wvalid, bready} = '0;
      {arid, arvalid, araddr, arlen, arburst, rready} = '0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_ready", {60'd0, awready, arready, wready, 1'b0}, 64'd0);
      check("rst_valid", {60'd0, bvalid, rvalid, rlast, 1'b0}, 64'd0);
      check("rst_ids", {58'd0, bid, bresp, rid, rresp}, 64'd0);
      check("rst_rdata", rdata, 64'd0);
      tick();
      rst = 1'b0;

      // Collision straight out of reset: write first, then read at the next IDLE.
      awaddr = BASE + 64'h100; awlen = 8'd0; awburst = BURST_INCR; awid = 1'b1; awvalid = 1'b1;
      araddr = BASE + 64'h100; arlen = 8'd0; arburst = BURST_INCR; arid = 1'b0; arvalid = 1'b1;
      @(negedge clk);
      check("arb1_aw", {63'd0, awready}, 64'd1);
      check("arb1_ar", {63'd0, arready}, 64'd0);
      tick();
      awvalid = 1'b0;
      cur_addr = BASE + 64'h100; cur_burst = BURST_INCR;
      @(negedge clk);
      check("busy_ar", {63'd0, arready}, 64'd0);
      tick();
      wq.push_back(64'hA5A5_0000_1234_5678);
      w_beats(1, 8'hFF, 0, e);
      awaddr = BASE + 64'h108; awvalid = 1'b1;
      b_wait(1'b1, e ? RESP_SLVERR : RESP_OKAY);
      @(negedge clk);
      check("arb2_ar", {63'd0, arready}, 64'd1);
      check("arb2_aw", {63'd0, awready}, 64'd0);
      push_read(BASE + 64'h100, 8'd0, BURST_INCR, 1'b0);
      tick();
      arvalid = 1'b0; awvalid = 1'b0;
      r_collect(1, 0, 1);

      // Single write and read-back.
      aw_req(BASE + 64'h10, 8'd0, BURST_INCR, 1'b0);
      wq.push_back(64'h1122_3344_5566_7788);
      w_beats(1, 8'hFF, 0, e);
      b_wait(1'b0, RESP_OKAY);
      ar_req(BASE + 64'h10, 8'd0, BURST_INCR, 1'b1);
      r_collect(1, 0, 1);

      // 8-beat INCR burst with data = beat index.
      aw_req(BASE, 8'd7, BURST_INCR, 1'b1);
      for (int k = 0; k < 8; k++) wq.push_back(64'(k));
      w_beats(8, 8'hFF, 7, e);
      b_wait(1'b1, RESP_OKAY);
      ar_req(BASE, 8'd7, BURST_INCR, 1'b0);
      r_collect(8, 0, 1);

      // Partial strobe over a zeroed word.
      aw_req(BASE + 64'h200, 8'd1, BURST_INCR, 1'b0);
      wq.push_back(64'd0);
      wq.push_back(64'd0);
      w_beats(2, 8'hFF, 1, e);
      b_wait(1'b0, RESP_OKAY);
      aw_req(BASE + 64'h200, 8'd0, BURST_INCR, 1'b0);
      wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      w_beats(1, 8'h0F, 0, e);
      b_wait(1'b0, RESP_OKAY);
      ar_req(BASE + 64'h200, 8'd0, BURST_INCR, 1'b1);
      r_collect(1, 0, 1);
      check("strobe_model", model[longint'(64'h40)], 64'h0000_0000_FFFF_FFFF);

      // Out-of-range write aliases word 0 after truncation; RAM must stay untouched.
      aw_req(64'h0, 8'd0, BURST_INCR, 1'b1);
      wq.push_back(64'hDEAD_BEEF_DEAD_BEEF);
      w_beats(1, 8'hFF, 0, e);
      b_wait(1'b1, RESP_SLVERR);
      ar_req(BASE, 8'd0, BURST_INCR, 1'b0);
      r_collect(1, 0, 1);

      // WLAST early on a len-3 burst.
      aw_req(BASE + 64'h300, 8'd3, BURST_INCR, 1'b1);
      for (int k = 0; k < 4; k++) wq.push_back(64'h300 + 64'(k));
      w_beats(4, 8'hFF, 1, e);
      b_wait(1'b1, RESP_SLVERR);

      // FIXED burst: both beats hit the same word.
      aw_req(BASE + 64'h400, 8'd1, BURST_FIXED, 1'b0);
      wq.push_back(64'h1111);
      wq.push_back(64'h2222);
      w_beats(2, 8'hFF, 1, e);
      b_wait(1'b0, RESP_OKAY);
      ar_req(BASE + 64'h400, 8'd1, BURST_FIXED, 1'b1);
      r_collect(2, 0, 1);

      // Read one past the top of memory.
      ar_req(LIMIT, 8'd0, BURST_INCR, 1'b1);
      r_collect(1, 0, 1);

      // Max-length read over an unmapped region.
      ar_req(LIMIT, 8'd255, BURST_INCR, 1'b0);
      r_collect(256, 0, 1);

      // 16-beat random data, read back under random backpressure.
      aw_req(BASE + 64'h1000, 8'd15, BURST_INCR, 1'b0);
      for (int k = 0; k < 16; k++) wq.push_back({$urandom, $urandom});
      w_beats(16, 8'hFF, 15, e);
      b_wait(1'b0, RESP_OKAY);
      ar_req(BASE + 64'h1000, 8'd15, BURST_INCR, 1'b1);
      r_collect(16, 1, 1);

      // Reset after five beats of a 16-beat read.
      ar_req(BASE + 64'h1000, 8'd15, BURST_INCR, 1'b0);
      r_collect(5, 0, 0);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("mid_rst_ready", {61'd0, awready, arready, wready}, 64'd0);
      check("mid_rst_valid", {61'd0, bvalid, rvalid, rlast}, 64'd0);
      tick();
      rst = 1'b0;
      sb.delete();
      ar_req(BASE + 64'h10, 8'd0, BURST_INCR, 1'b1);
      r_collect(1, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
